// File: rtl/cu_sequencer.sv
// Program sequencer: byte-wide program load, one-at-a-time issue to the compute unit.
// Define CU_SEQ_LOOP_EN to repeat the program until HALT or stop.
module cu_sequencer #(
    parameter int DEPTH  = 8,
    parameter int ADDR_W = 3
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [7:0]      byte_in,
    input  logic            byte_valid,
    input  logic            clear,
    input  logic            start,
    input  logic            stop,
    output logic [15:0]     cu_instruction,
    output logic            cu_en,
    input  logic [7:0]      cu_data,
    input  logic            cu_data_valid,
    input  logic [3:0]      cu_reg_id,
    output logic [7:0]      result_data,
    output logic [3:0]      result_reg,
    output logic            result_valid,
    output logic            busy,
    output logic            done,
    output logic [ADDR_W:0] prog_len,
    output logic            full
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_DONE
    } state_e;

    localparam logic [ADDR_W:0] ONE     = (ADDR_W+1)'(1);
    localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);

    logic [15:0] mem_q [DEPTH];

    state_e          state_q, state_d;
    logic [ADDR_W:0] pc_q, pc_d;
    logic [ADDR_W:0] len_q, len_d;
    logic            phase_q, phase_d;
    logic            stop_pend_q, stop_pend_d;
    logic [7:0]      hi_q, hi_d;

    logic [15:0] instr_q, instr_d;
    logic        en_q, en_d;
    logic [7:0]  rdata_q, rdata_d;
    logic [3:0]  rreg_q, rreg_d;
    logic        rvalid_q, rvalid_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        full_q, full_d;

    logic              wr_en;
    logic [15:0]       cur_word;
    logic [15:0]       nxt_word;
    logic [ADDR_W:0]   pc_inc;

    assign cur_word = mem_q[pc_q[ADDR_W-1:0]];
    assign nxt_word = mem_q[pc_d[ADDR_W-1:0]];
    assign pc_inc   = pc_q + ONE;

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        len_d       = len_q;
        phase_d     = phase_q;
        hi_d        = hi_q;
        stop_pend_d = stop_pend_q;
        wr_en       = 1'b0;
        rdata_d     = rdata_q;
        rreg_d      = rreg_q;
        rvalid_d    = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    pc_d        = '0;
                    stop_pend_d = 1'b0;
                    phase_d     = 1'b0;
                    state_d     = (len_q == '0) ? S_DONE : S_ISSUE;
                end else if (clear) begin
                    len_d   = '0;
                    phase_d = 1'b0;
                end else if (byte_valid && !full_q) begin
                    if (!phase_q) begin
                        hi_d    = byte_in;
                        phase_d = 1'b1;
                    end else begin
                        wr_en   = 1'b1;
                        len_d   = len_q + ONE;
                        phase_d = 1'b0;
                    end
                end
            end
            S_ISSUE: begin
                if (stop) stop_pend_d = 1'b1;
                state_d = (cur_word[15:12] == 4'hF) ? S_DONE : S_WAIT;
            end
            S_WAIT: begin
                if (cu_data_valid) begin
                    rdata_d  = cu_data;
                    rreg_d   = cu_reg_id;
                    rvalid_d = 1'b1;
                end
                pc_d = pc_inc;
                if (stop_pend_q || stop) begin
                    state_d = S_DONE;
                end else if (pc_inc == len_q) begin
`ifdef CU_SEQ_LOOP_EN
                    pc_d    = '0;
                    state_d = S_ISSUE;
`else
                    state_d = S_DONE;
`endif
                end else begin
                    state_d = S_ISSUE;
                end
            end
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        // Outputs are registered from the next state so they hold for the whole cycle.
        en_d    = (state_d == S_ISSUE) && (nxt_word[15:12] != 4'hF);
        instr_d = en_d ? nxt_word : 16'h0000;
        busy_d  = (state_d != S_IDLE);
        done_d  = (state_d == S_DONE);
        full_d  = (len_d == DEPTH_L);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            pc_q        <= '0;
            len_q       <= '0;
            phase_q     <= 1'b0;
            stop_pend_q <= 1'b0;
            hi_q        <= 8'h00;
            instr_q     <= 16'h0000;
            en_q        <= 1'b0;
            rdata_q     <= 8'h00;
            rreg_q      <= 4'h0;
            rvalid_q    <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            full_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            len_q       <= len_d;
            phase_q     <= phase_d;
            stop_pend_q <= stop_pend_d;
            hi_q        <= hi_d;
            instr_q     <= instr_d;
            en_q        <= en_d;
            rdata_q     <= rdata_d;
            rreg_q      <= rreg_d;
            rvalid_q    <= rvalid_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            full_q      <= full_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en && !rst) begin
            mem_q[len_q[ADDR_W-1:0]] <= {hi_q, byte_in};
        end
    end

    assign cu_instruction = instr_q;
    assign cu_en          = en_q;
    assign result_data    = rdata_q;
    assign result_reg     = rreg_q;
    assign result_valid   = rvalid_q;
    assign busy           = busy_q;
    assign done           = done_q;
    assign prog_len       = len_q;
    assign full           = full_q;

endmodule
